mips_data_mem_responder: RTL
============================

Name: mips_data_mem_responder

Overview:
- Memory-side end of the MIPS core's data-memory interface.
- Accepts read/write requests driven by the core on mem_adr / mem_out / mem_read / mem_write, and returns read data on mem_in.
- Backs requests with an on-chip word array and a programmable wait-state count.
- Signals completion with a one-cycle mem_ready pulse, and flags illegal accesses on mem_err.

Parameters:
- DEPTH_LOG2, 10, log2 of word count; array holds 2**DEPTH_LOG2 32-bit words.
- WAIT_STATES, 2, extra cycles between request accept and response (0 allowed, max 15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous and active-high.
- mem_adr  input  32  byte address from core.
- mem_out  input  32  write data from core.
- mem_read  input  1  read request.
- mem_write  input  1  write request.
- mem_in  output  32  read data to core, registered.
- mem_ready  output  1  one-cycle completion pulse.
- mem_err  output  1  error flag, valid with mem_ready.

Behaviour:
- Reset values: state IDLE, wait counter 0, mem_in 0, mem_ready 0, mem_err 0. Array contents are not reset.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - Accepts a request when mem_read | mem_write is 1.
  - Captures address, write data, op and error class into registers.
  - Goes to WAIT with counter = WAIT_STATES, or directly to RESP if WAIT_STATES = 0.
- WAIT:
  - Counter decrements each cycle; goes to RESP when it reaches 1.
  - Core inputs are ignored here; only the captured values are used.
- Latency: request accepted at edge t; mem_ready is high during cycle t+1+WAIT_STATES.
- RESP:
  - mem_ready = 1 for exactly one cycle, then unconditionally back to IDLE.
  - Next accept is no earlier than the cycle after RESP.
  - A request still held after ready is treated as new and re-executed.
- Read:
  - mem_in is loaded with array[(adr-BASE_ADDR)>>2] on the edge entering RESP.
  - mem_in holds that value until the next response.
- Write:
  - array[(adr-BASE_ADDR)>>2] <= captured mem_out on the edge entering RESP.
  - mem_in is unchanged.
  - A read issued after a write's ready returns the new data.
- Error classes, evaluated on the captured request:
  - mem_adr[1:0] != 0 (misaligned);
  - (adr - BASE_ADDR) >= 4*2**DEPTH_LOG2, using unsigned 32-bit subtraction so addresses below BASE wrap and count as out of range;
  - mem_read and mem_write both 1.
- Error response: same latency as a normal access, mem_err = 1 with mem_ready, no array write, mem_in forced to 0.
- mem_err is 0 whenever mem_ready is 0.
- Reset mid-operation:
  - Sync reset wins on any edge and aborts the pending request.
  - A write whose commit edge coincides with rst = 1 is not performed.
- Array access is single-port, word-indexed with DEPTH_LOG2 index bits taken from (adr-BASE_ADDR)[DEPTH_LOG2+1:2].
- Arithmetic is unsigned and 32 bits wide throughout.

Decomposition:
- Package mips_mem_pkg contains:
  - state enum {IDLE, WAIT, RESP};
  - WORD_W = 32;
  - error-class localparams: ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_BOTH;
  - a function computing in-range / word index from address, BASE_ADDR and DEPTH_LOG2.
- One sub-module, mem_word_array: a synchronous single-port RAM with ports clk, we, idx, wdata, rdata. rdata is registered and read on the same edge as an inactive we.
- FSM, counter and error logic stay in the top module.

Test Plan (default parameters unless noted):
1. Write then read: write 32'hDEAD_BEEF at adr 32'h10 with mem_write held. Ready must arrive exactly 3 cycles after accept with err = 0. A following read of 32'h10 must return mem_in = 32'hDEAD_BEEF with ready 3 cycles after accept.
2. Misaligned: read at 32'h0000_0006 -> ready after 3 cycles, mem_err = 1, mem_in = 0. A subsequent read of word 32'h4 must show prior contents unchanged.
3. Range and both-asserted cases:
   - Read at 32'h0000_1000 (= 4*1024) -> mem_err = 1.
   - With BASE_ADDR = 32'h100, read at 32'h0 -> mem_err = 1.
   - mem_read = mem_write = 1 at 32'h8 -> mem_err = 1 and array[2] unchanged.
4. WAIT_STATES = 0: back-to-back held read at 32'h0 -> mem_ready pulses every 2nd cycle, never 2 consecutive cycles high. Changing mem_adr during WAIT (with WAIT_STATES = 2) must not affect the returned data.
5. Reset mid-operation: write 32'h1234_5678 to 32'h20, then assert rst for 1 cycle in the WAIT cycle -> no ready, outputs return to 0. A later read of 32'h20 returns the previously written value, not 32'h1234_5678.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and helpers for the MIPS data-memory responder.
//   state_t      : responder FSM states (IDLE, WAIT, RESP)
//   WORD_W       : data/address word width
//   ERR_*        : error class captured with each request
//   addr_decode  : byte address -> {in-range flag, word index}
// ---------------------------------------------------------------------------
package mips_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Error classes in priority order: a read+write conflict is reported
  // ahead of a misaligned address, which is reported ahead of range.
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_BOTH  = 2'd3;

  typedef struct packed {
    logic              in_range;
    logic [WORD_W-3:0] word_idx;
  } addr_dec_t;

  // Offset is unsigned 32-bit, so an address below the base wraps to a
  // huge offset and lands out of range on its own.
  function automatic addr_dec_t addr_decode(input logic [WORD_W-1:0] adr,
                                            input logic [WORD_W-1:0] base,
                                            input int unsigned       depth_log2);
    logic [WORD_W-1:0] off;
    addr_dec_t         dec;
    off          = adr - base;
    dec.word_idx = off[WORD_W-1:2];
    dec.in_range = ((off >> (depth_log2 + 2)) == '0);
    return dec;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// ---------------------------------------------------------------------------
// mem_word_array
// Synchronous single-port word RAM. A write happens on an edge with we=1;
// on any edge with we=0 the addressed word is read into rdata.
//   clk   : clock, rising edge
//   we    : write enable
//   idx   : word index
//   wdata : write data
//   rdata : registered read data (holds across write edges)
// ---------------------------------------------------------------------------
module mem_word_array
  import mips_mem_pkg::*;
#(
  parameter int IDX_W = 10,
  parameter int W     = WORD_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata
);

  // NOTE: the storage array has no reset; clearing a RAM would turn it
  // into flops and the responder never relies on initial contents.
  logic [W-1:0] mem_q [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end else begin
      rdata <= mem_q[idx];
    end
  end

endmodule

// File: rtl/mips_data_mem_responder.sv
// ---------------------------------------------------------------------------
// mips_data_mem_responder
// Memory side of the MIPS core data interface: accepts one read or write,
// waits WAIT_STATES cycles, then pulses mem_ready for one cycle with
// mem_err flagging misaligned, out-of-range or read+write requests.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   mem_adr   : byte address from core
//   mem_out   : write data from core
//   mem_read  : read request
//   mem_write : write request
//   mem_in    : read data to core, held until the next response
//   mem_ready : one-cycle completion pulse
//   mem_err   : error flag, only ever high together with mem_ready
// ---------------------------------------------------------------------------
module mips_data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned       DEPTH_LOG2  = 10,
  parameter int unsigned       WAIT_STATES = 2,
  parameter logic [WORD_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] mem_adr,
  input  logic [WORD_W-1:0] mem_out,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [WORD_W-1:0] mem_in,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [WORD_W-1:0]       wdata_q;
  logic                    wr_q;
  logic [1:0]              err_q;
  logic [WORD_W-1:0]       mem_in_q;
  logic [WORD_W-1:0]       mem_in_d;
  logic                    mem_ready_q;
  logic                    mem_err_q;

  addr_dec_t               live_dec;
  logic [DEPTH_LOG2-1:0]   live_idx;
  logic [1:0]              live_err;
  logic                    req;
  logic                    in_idle;
  logic                    enter_resp;
  logic [DEPTH_LOG2-1:0]   ram_idx;
  logic [WORD_W-1:0]       ram_wdata;
  logic [WORD_W-1:0]       ram_rdata;
  logic                    ram_we;
  logic                    sel_wr;
  logic [1:0]              sel_err;

  assign req      = mem_read | mem_write;
  assign in_idle  = (state_q == IDLE);
  assign live_dec = addr_decode(mem_adr, BASE_ADDR, DEPTH_LOG2);
  assign live_idx = live_dec.word_idx[DEPTH_LOG2-1:0];

  always_comb begin
    // NOTE: default first so every path assigns live_err (no latch).
    live_err = ERR_NONE;
    if (mem_read && mem_write) begin
      live_err = ERR_BOTH;
    end else if (mem_adr[1:0] != 2'b00) begin
      live_err = ERR_ALIGN;
    end else if (!live_dec.in_range) begin
      live_err = ERR_RANGE;
    end
  end

  // With zero wait states the RAM is touched on the accept edge itself,
  // before the capture registers are loaded, so the live request is used
  // in IDLE and the captured one everywhere else.
  assign ram_idx   = in_idle ? live_idx  : idx_q;
  assign ram_wdata = in_idle ? mem_out   : wdata_q;
  assign sel_wr    = in_idle ? mem_write : wr_q;
  assign sel_err   = in_idle ? live_err  : err_q;

  assign enter_resp = (in_idle && req && (WAIT_STATES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd1));

  // Reset on the commit edge cancels the write.
  assign ram_we = enter_resp && sel_wr && (sel_err == ERR_NONE) && !rst;

  mem_word_array #(
    .IDX_W (DEPTH_LOG2),
    .W     (WORD_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM rdata is loaded on the edge entering RESP; during RESP it is
  // forwarded, and on leaving RESP it is parked in mem_in_q so the value
  // holds while the RAM keeps reading other words.
  assign mem_in_d = (err_q != ERR_NONE) ? '0 :
                    (wr_q ? mem_in_q : ram_rdata);
  assign mem_in    = (state_q == RESP) ? mem_in_d : mem_in_q;
  assign mem_ready = mem_ready_q;
  assign mem_err   = mem_err_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      err_q       <= ERR_NONE;
      mem_in_q    <= '0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      mem_ready_q <= enter_resp;
      mem_err_q   <= enter_resp && (sel_err != ERR_NONE);
      unique case (state_q)
        IDLE: begin
          if (req) begin
            idx_q   <= live_idx;
            wdata_q <= mem_out;
            wr_q    <= mem_write;
            err_q   <= live_err;
            if (WAIT_STATES == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          mem_in_q <= mem_in_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
